minilogix_cfg_loader: RTL and testbench
=======================================

// Module: minilogix_cfg_loader
//
// PURPOSE
//  Configuration sequencer for the minilogix1 programmable logic core. Accepts config bytes
//  from a host-side valid/ready stream and turns them into the core's serial load protocol
//  (load_en / load_clk / load_dat). The serial clock is generated from the system clock.
//  Sits between the TT pin/host interface and the minilogix1 load port; only one load at a time.
//
// PARAMETERS
//  CFG_BITS  20  total configuration bits shifted per load (>=1); byte count NB = ceil(CFG_BITS/8)
//  CLK_DIV   2   clk cycles per load_clk half-period (>=1)
//
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  i_start       in   1  request a load; sampled only in IDLE
//  i_abort       in   1  cancel the load in progress
//  i_byte_data   in   8  config byte, MSB shifted first
//  i_byte_valid  in   1  i_byte_data valid
//  o_byte_ready  out  1  loader takes i_byte_data this cycle if valid
//  o_load_en     out  1  to minilogix1 i_load_en
//  o_load_clk    out  1  to minilogix1 i_load_clk (core samples on rising edge)
//  o_load_dat    out  1  to minilogix1 i_load_dat
//  o_busy        out  1  load in progress (state != IDLE)
//  o_done        out  1  one-cycle pulse: load completed normally
//  o_err         out  1  sticky: last load aborted; cleared by next accepted start
//
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. All outputs registered.
//  - States: IDLE, FETCH, LOW, HIGH, TAIL.
//  - IDLE: i_start=1 -> FETCH next cycle; o_load_en=1, o_err=0 from that cycle on.
//  - FETCH: o_byte_ready=1; on valid&ready, latch byte into 8-bit shift reg -> LOW. Without valid,
//    wait indefinitely (load_clk held 0, load_en held 1).
//  - LOW: o_load_clk=0, o_load_dat=shift[7], CLK_DIV cycles -> HIGH.
//  - HIGH: o_load_clk=1, load_dat unchanged, CLK_DIV cycles; at exit shift left, bits_left--.
//    bits_left==0 -> TAIL; byte exhausted (8 bits) -> FETCH; else -> LOW.
//  - load_dat stable for CLK_DIV cycles before and after each rising edge of o_load_clk.
//  - Last byte: only CFG_BITS mod 8 MSBs shifted (all 8 if mod is 0); remaining LSBs dropped.
//  - TAIL: load_clk=0 for CLK_DIV cycles -> IDLE; on entry to IDLE o_load_en=0, o_load_dat=0,
//    o_done=1 for one cycle.
//  - Exactly CFG_BITS rising edges of o_load_clk per completed load; load_clk never toggles
//    while o_load_en=0.
//  - i_abort (any non-IDLE state, highest priority): next cycle IDLE, load_en/clk/dat=0,
//    o_err=1, no o_done; a partially shifted byte is discarded. i_abort in IDLE: no effect.
//  - i_start while busy: ignored. i_start and i_abort same cycle in IDLE: start wins.
//  - rst_n low mid-load: immediate return to reset values (core config considered invalid).
//  - bits_left width $clog2(CFG_BITS+1); bit-in-byte counter 3 bits; divider $clog2(CLK_DIV).
//
// STRUCTURE
//  - minilogix_pkg: state enum, function to compute NB and counter widths.
//  - One sub-module: minilogix_clkdiv (counts CLK_DIV cycles, emits phase_end pulse, restartable).
//  - FSM, shift register and bit counters live in this module.
//
// TESTING (CFG_BITS=20, CLK_DIV=2 unless noted)
//  1 start at cycle 0, bytes 0xA5,0x3C,0xF0 always valid -> load_dat at rising edges
//    1010_0101_0011_1100_1111; 20 rising edges; load_en high cycles 1..85; o_done at cycle 86.
//  2 as 1 but byte 2 valid 10 cycles late -> load_clk low, load_en high during gap; same bits.
//  3 abort during byte 2, HIGH phase -> next cycle load_en/clk/dat=0, o_err=1, no o_done;
//    new start clears o_err and a full load then succeeds.
//  4 i_start pulsed while busy -> ignored, bit stream identical to scenario 1.
//  5 rst_n low at cycle 40 -> all outputs 0 asynchronously; after release, idle until start.
//  6 CFG_BITS=8, CLK_DIV=1, byte 0x81 -> 8 edges, bits 1000_0001, single FETCH, o_done once.

Source files
------------

// File: rtl/minilogix_pkg.sv
// minilogix_pkg: shared FSM state encoding and sizing helpers for the minilogix config loader.
package minilogix_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, TAIL} state_t;

    function automatic int num_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/minilogix_clkdiv.sv
// minilogix_clkdiv: counts DIV cycles while run is high and pulses phase_end on the last one.
// Dropping run clears the count, so every phase restarts from zero.
module minilogix_clkdiv
    import minilogix_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase_end
);

    localparam int W = cnt_width(DIV);

    logic [W-1:0] cnt;

    assign phase_end = run && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (phase_end || !run) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/minilogix_cfg_loader.sv
// minilogix_cfg_loader: turns a valid/ready byte stream into the minilogix1 serial load protocol
// (load_en / load_clk / load_dat), MSB first, with load_clk derived from clk by CLK_DIV.
module minilogix_cfg_loader
    import minilogix_pkg::*;
#(
    parameter int CFG_BITS = 20,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_byte_data,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    output logic       o_load_en,
    output logic       o_load_clk,
    output logic       o_load_dat,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int BW = cnt_width(CFG_BITS + 1);

    state_t        state, state_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [BW-1:0] bits_left, bits_left_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          run, phase_end, take, dat_nxt;

    assign run  = (state == LOW) || (state == HIGH) || (state == TAIL);
    assign take = (state == FETCH) && i_byte_valid && o_byte_ready;

    minilogix_clkdiv #(.DIV(CLK_DIV)) u_clkdiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .phase_end (phase_end)
    );

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bits_left_nxt = bits_left;
        bit_cnt_nxt   = bit_cnt;
        case (state)
            IDLE: if (i_start) begin
                state_nxt     = FETCH;
                bits_left_nxt = BW'(CFG_BITS);
                bit_cnt_nxt   = 3'd0;
            end
            FETCH: if (take) begin
                state_nxt = LOW;
                shift_nxt = i_byte_data;
            end
            LOW: if (phase_end) state_nxt = HIGH;
            // The last byte may end early: bits_left reaching zero wins over byte exhaustion.
            HIGH: if (phase_end) begin
                shift_nxt     = {shift[6:0], 1'b0};
                bits_left_nxt = bits_left - BW'(1);
                bit_cnt_nxt   = bit_cnt + 3'd1;
                state_nxt     = (bits_left == BW'(1)) ? TAIL : (bit_cnt == 3'd7) ? FETCH : LOW;
            end
            TAIL: if (phase_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_abort && state != IDLE)
            state_nxt = IDLE;
        if (state_nxt == IDLE)
            shift_nxt = 8'h00;
        dat_nxt = (state_nxt == LOW) ? shift_nxt[7] : (state_nxt == IDLE) ? 1'b0 : o_load_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift        <= '0;
            bits_left    <= '0;
            bit_cnt      <= '0;
            o_byte_ready <= 1'b0;
            o_load_en    <= 1'b0;
            o_load_clk   <= 1'b0;
            o_load_dat   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift        <= shift_nxt;
            bits_left    <= bits_left_nxt;
            bit_cnt      <= bit_cnt_nxt;
            o_byte_ready <= state_nxt == FETCH;
            o_load_en    <= state_nxt != IDLE;
            o_load_clk   <= state_nxt == HIGH;
            o_load_dat   <= dat_nxt;
            o_busy       <= state_nxt != IDLE;
            o_done       <= (state == TAIL) && phase_end && !i_abort;
            if (state == IDLE && i_start)
                o_err <= 1'b0;
            else if (state != IDLE && i_abort)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_minilogix_cfg_loader.sv
// tb_minilogix_cfg_loader: randomized self-checking bench for two loader configurations
// (20 bits / div 2 and 8 bits / div 1) against a bit-list reference model.
module tb_minilogix_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [2];
    logic       abort [2];
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ready [2];
    logic       en    [2];
    logic       lclk  [2];
    logic       ldat  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       err   [2];

    always #5 clk = ~clk;

    minilogix_cfg_loader #(.CFG_BITS(20), .CLK_DIV(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
        .i_byte_data(data[0]), .i_byte_valid(valid[0]), .o_byte_ready(ready[0]),
        .o_load_en(en[0]), .o_load_clk(lclk[0]), .o_load_dat(ldat[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
    );

    minilogix_cfg_loader #(.CFG_BITS(8), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
        .i_byte_data(data[1]), .i_byte_valid(valid[1]), .o_byte_ready(ready[1]),
        .o_load_en(en[1]), .o_load_clk(lclk[1]), .o_load_dat(ldat[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
    );

    int n_checks = 0;
    int n_fails  = 0;

    function automatic int cbits(input int d);
        return d == 0 ? 20 : 8;
    endfunction

    function automatic int cdiv(input int d);
        return d == 0 ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cumulative observations per DUT; load tasks work on differences.
    logic [31:0] bits   [2] = '{32'd0, 32'd0};
    int          edges  [2] = '{0, 0};
    int          en_cyc [2] = '{0, 0};
    int          dones  [2] = '{0, 0};
    int          viol   [2] = '{0, 0};
    int          since  [2] = '{0, 0};
    logic        pclk   [2] = '{1'b0, 1'b0};
    logic        pdat   [2] = '{1'b0, 1'b0};
    logic        pen    [2] = '{1'b0, 1'b0};
    logic        edat   [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ldat[d] !== pdat[d]) since[d] = 0; else since[d]++;
            if (lclk[d] && !pclk[d]) begin
                edges[d]++;
                bits[d] = {bits[d][30:0], ldat[d]};
                edat[d] = ldat[d];
                if (since[d] < cdiv(d)) viol[d]++;
            end
            if (lclk[d] && (ldat[d] !== edat[d] || !en[d])) viol[d]++;
            if (done[d] && (en[d] || !pen[d])) viol[d]++;
            en_cyc[d] += int'(en[d]);
            dones[d]  += int'(done[d]);
            pclk[d] = lclk[d];
            pdat[d] = ldat[d];
            pen[d]  = en[d];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: the first cb bits of the byte sequence, MSB of each byte first.
    function automatic logic [31:0] model_bits(input int cb, input logic [7:0] b0, b1, b2);
        logic [31:0] r = '0;
        logic [7:0]  byt;
        for (int i = 0; i < cb; i++) begin
            byt = (i / 8 == 0) ? b0 : (i / 8 == 1) ? b1 : b2;
            r = {r[30:0], byt[7 - i % 8]};
        end
        return r;
    endfunction

    task automatic load(input int d, input logic [7:0] b0, b1, b2, input int g0, g1, g2,
                        input int start_cyc, input int abort_edge, input bit abort_at_start);
        logic [7:0]  bs [3];
        int          gs [3];
        int          cb = cbits(d);
        int          nb = (cbits(d) + 7) / 8;
        int          e0 = edges[d];
        int          c0 = en_cyc[d];
        int          dn0 = dones[d];
        int          v0 = viol[d];
        int          idx = 0, gcnt, cyc = 1, k, exp_en;
        bit          pend = 0, aborted = 0;
        logic [31:0] mask;
        bs = '{b0, b1, b2};
        gs = '{g0, g1, g2};
        gcnt = gs[0];
        start[d] = 1'b1;
        abort[d] = abort_at_start;
        tick();
        start[d] = 1'b0;
        abort[d] = 1'b0;
        check($sformatf("start_en%0d", d), {31'd0, en[d]}, 32'd1);
        check($sformatf("start_err%0d", d), {31'd0, err[d]}, 32'd0);
        for (k = 0; k < 3000; k++) begin
            if (pend) begin
                valid[d] = 1'b0;
                idx++;
                if (idx < nb) gcnt = gs[idx];
                pend = 0;
            end
            start[d] = (cyc == start_cyc);
            abort[d] = 1'b0;
            if (abort_edge >= 0 && !aborted && edges[d] - e0 >= abort_edge && lclk[d]) begin
                abort[d] = 1'b1;
                aborted = 1;
            end
            if (idx < nb && !valid[d] && ready[d]) begin
                if (gcnt == 0) begin
                    valid[d] = 1'b1;
                    data[d] = bs[idx];
                end else gcnt--;
            end
            if (valid[d] && ready[d]) pend = 1;
            if (!busy[d]) break;
            tick();
            cyc++;
        end
        valid[d] = 1'b0;
        start[d] = 1'b0;
        abort[d] = 1'b0;
        if (k == 3000) begin
            check($sformatf("timeout%0d", d), 32'd1, 32'd0);
        end else if (aborted) begin
            check($sformatf("abort_pins%0d", d), {29'd0, en[d], lclk[d], ldat[d]}, 32'd0);
            check($sformatf("abort_err%0d", d), {31'd0, err[d]}, 32'd1);
            check($sformatf("abort_nodone%0d", d), dones[d] - dn0, 32'd0);
        end else begin
            exp_en = nb + 2 * cb * cdiv(d) + cdiv(d);
            for (int i = 0; i < nb; i++) exp_en += gs[i];
            mask = (32'd1 << cb) - 32'd1;
            check($sformatf("edges%0d", d), edges[d] - e0, cb);
            check($sformatf("bits%0d", d), bits[d] & mask, model_bits(cb, b0, b1, b2));
            check($sformatf("en_cycles%0d", d), en_cyc[d] - c0, exp_en);
            check($sformatf("done_cycle%0d", d), cyc, exp_en + 1);
            check($sformatf("done_once%0d", d), dones[d] - dn0, 32'd1);
            check($sformatf("err_clear%0d", d), {31'd0, err[d]}, 32'd0);
        end
        check($sformatf("protocol%0d", d), viol[d] - v0, 32'd0);
        repeat (3) tick();
    endtask

    function automatic logic [6:0] outs(input int d);
        return {ready[d], en[d], lclk[d], ldat[d], busy[d], done[d], err[d]};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            abort[d] = 1'b0;
            valid[d] = 1'b0;
            data[d]  = 8'h00;
        end
        repeat (3) tick();
        check("reset_a", {25'd0, outs(0)}, 32'd0);
        check("reset_b", {25'd0, outs(1)}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        load(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, -1, -1, 0);
        load(0, 8'hA5, 8'h3C, 8'hF0, 0, 10, 0, -1, -1, 0);
        load(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, -1, 12, 0);
        load(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, -1, -1, 0);
        load(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 30, -1, 0);
        load(0, 8'h5A, 8'hC3, 8'h0F, 0, 0, 0, -1, -1, 1);

        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        tick();
        check("idle_abort", {30'd0, busy[0], err[0]}, 32'd0);

        load(1, 8'h81, 8'h00, 8'h00, 0, 0, 0, -1, -1, 0);
        load(1, 8'h81, 8'h00, 8'h00, 0, 0, 0, -1, 3, 0);
        for (int r = 0; r < 4; r++) begin
            load(0, 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(2, 80), -1, 0);
            load(1, 8'($urandom), 8'h00, 8'h00, $urandom_range(0, 5), 0, 0,
                 $urandom_range(2, 15), -1, 0);
        end

        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        repeat (38) tick();
        check("busy_before_rst", {31'd0, busy[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_a", {25'd0, outs(0)}, 32'd0);
        valid[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_after_rst", {25'd0, outs(0)}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
